// File: rtl/clock_divider_multi.sv
// N-channel runtime-scalable clock divider with freeze, glitch-free rescale and single-step.
// Outputs are registered; scale changes only land on phase boundaries, so no runt phases.
module clock_divider_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
) (
  input  logic                        RawClock,
  input  logic                        Reset_n,
  input  logic [CHANNELS*WIDTH-1:0]   ClockScale,
  input  logic [CHANNELS-1:0]         Enable,
  input  logic [CHANNELS-1:0]         StepMode,
  input  logic [CHANNELS-1:0]         StepReq,
  output logic [CHANNELS-1:0]         ClockOut,
  output logic [CHANNELS-1:0]         RiseTick,
  output logic [CHANNELS-1:0]         Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP_HI = 2'd2,
    STEP_LO = 2'd3
  } state_t;

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [WIDTH-1:0] scale;
    logic             out, out_nxt;
    logic             tick, tick_nxt;
    logic             busy, busy_nxt;
    logic [WIDTH:0]   half;
    logic [WIDTH:0]   cnt_inc;
    logic             hit;

    assign scale   = ClockScale[i*WIDTH +: WIDTH];
    // Compare one bit wider than the counter so an all-ones scale cannot wrap.
    assign half    = (sh == '0) ? ONE : {1'b0, sh};
    assign cnt_inc = {1'b0, cnt} + ONE;
    assign hit     = (cnt_inc >= half);

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sh_nxt    = sh;
      out_nxt   = out;
      busy_nxt  = busy;
      tick_nxt  = 1'b0;

      if (Enable[i]) begin
        case (state)
          IDLE: begin
            cnt_nxt = '0;
            out_nxt = 1'b0;
            sh_nxt  = scale;
            if (!StepMode[i]) begin
              state_nxt = RUN;
            end else if (StepReq[i]) begin
              state_nxt = STEP_HI;
              out_nxt   = 1'b1;
              busy_nxt  = 1'b1;
            end
          end
          default: begin
            if (hit) begin
              cnt_nxt = '0;
              sh_nxt  = scale;
              case (state)
                RUN: begin
                  if (out) begin
                    out_nxt = 1'b0;
                    if (StepMode[i]) state_nxt = IDLE;
                  end else if (StepMode[i]) begin
                    // Park low instead of rising when step mode is requested.
                    state_nxt = IDLE;
                  end else begin
                    out_nxt = 1'b1;
                  end
                end
                STEP_HI: begin
                  out_nxt   = 1'b0;
                  state_nxt = STEP_LO;
                end
                default: begin
                  busy_nxt  = 1'b0;
                  state_nxt = StepMode[i] ? IDLE : RUN;
                end
              endcase
            end else begin
              cnt_nxt = cnt_inc[WIDTH-1:0];
            end
          end
        endcase
      end else if (state == IDLE) begin
        sh_nxt = scale;
      end

      tick_nxt = out_nxt & ~out;
    end

    always_ff @(posedge RawClock) begin
      if (!Reset_n) begin
        state <= StepMode[i] ? IDLE : RUN;
        cnt   <= '0;
        sh    <= scale;
        out   <= 1'b0;
        tick  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        sh    <= sh_nxt;
        out   <= out_nxt;
        tick  <= tick_nxt;
        busy  <= busy_nxt;
      end
    end

    assign ClockOut[i] = out;
    assign RiseTick[i] = tick;
    assign Busy[i]     = busy;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: a countdown reference model pushes the expected
// outputs each cycle; they are popped and compared after the edge, plus directed timing checks.
module tb_clock_divider_multi;

  localparam int CH = 2;
  localparam int W  = 4;

  logic              RawClock;
  logic              Reset_n;
  logic [CH*W-1:0]   ClockScale;
  logic [CH-1:0]     Enable;
  logic [CH-1:0]     StepMode;
  logic [CH-1:0]     StepReq;
  logic [CH-1:0]     ClockOut;
  logic [CH-1:0]     RiseTick;
  logic [CH-1:0]     Busy;
  logic [W-1:0]      scl0, scl1;

  assign ClockScale = {scl1, scl0};

  clock_divider_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .RawClock   (RawClock),
    .Reset_n    (Reset_n),
    .ClockScale (ClockScale),
    .Enable     (Enable),
    .StepMode   (StepMode),
    .StepReq    (StepReq),
    .ClockOut   (ClockOut),
    .RiseTick   (RiseTick),
    .Busy       (Busy)
  );

  initial RawClock = 1'b0;
  always #5 RawClock = ~RawClock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state 0=idle 1=run 2=step-high 3=step-low; rem counts down the phase.
  int   m_st  [CH];
  int   m_rem [CH];
  logic m_out [CH];
  logic m_tick[CH];
  logic m_busy[CH];

  logic [5:0] expq[$];

  function automatic int hval(input logic [W-1:0] s);
    return (s == '0) ? 1 : int'(s);
  endfunction

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      logic [W-1:0] s;
      s = (c == 0) ? scl0 : scl1;
      if (!Reset_n) begin
        m_out[c] = 1'b0; m_tick[c] = 1'b0; m_busy[c] = 1'b0;
        m_st[c]  = StepMode[c] ? 0 : 1;
        m_rem[c] = hval(s);
      end else begin
        m_tick[c] = 1'b0;
        if (m_st[c] == 0) begin
          m_rem[c] = hval(s);
          if (Enable[c]) begin
            if (!StepMode[c]) m_st[c] = 1;
            else if (StepReq[c]) begin
              m_st[c] = 2; m_out[c] = 1'b1; m_tick[c] = 1'b1; m_busy[c] = 1'b1;
            end
          end
        end else if (Enable[c]) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            m_rem[c] = hval(s);
            case (m_st[c])
              1: begin
                if (m_out[c]) begin
                  m_out[c] = 1'b0;
                  if (StepMode[c]) m_st[c] = 0;
                end else if (StepMode[c]) m_st[c] = 0;
                else begin m_out[c] = 1'b1; m_tick[c] = 1'b1; end
              end
              2: begin m_out[c] = 1'b0; m_st[c] = 3; end
              default: begin m_busy[c] = 1'b0; m_st[c] = StepMode[c] ? 0 : 1; end
            endcase
          end
        end
      end
    end
  endtask

  int   rt0, rt1, bz0, hi0;
  int   cyc, last_rise, prev_rise;
  logic prev_co0;

  task automatic step_clk();
    logic [5:0] obs, exp;
    model_step();
    expq.push_back({m_out[1], m_out[0], m_tick[1], m_tick[0], m_busy[1], m_busy[0]});
    @(posedge RawClock);
    #1;
    cyc++;
    obs = {ClockOut, RiseTick, Busy};
    exp = expq.pop_front();
    chk("cycle", 32'(obs), 32'(exp));
    if (RiseTick[0]) rt0++;
    if (RiseTick[1]) rt1++;
    if (Busy[0]) bz0++;
    if (ClockOut[0]) hi0++;
    if (ClockOut[0] && !prev_co0) begin prev_rise = last_rise; last_rise = cyc; end
    prev_co0 = ClockOut[0];
  endtask

  task automatic clr();
    rt0 = 0; rt1 = 0; bz0 = 0; hi0 = 0;
  endtask

  initial begin
    int n, hi, lo;
    logic [CH-1:0] snap;
    cyc = 0; last_rise = 0; prev_rise = 0; prev_co0 = 1'b0;
    clr();
    Reset_n = 1'b0; scl0 = 4'd4; scl1 = 4'd4;
    Enable = 2'b11; StepMode = 2'b00; StepReq = 2'b00;

    // Reset, first rise on 4th edge, period 8.
    repeat (3) begin step_clk(); chk("rst_out", 32'(ClockOut), 0); end
    Reset_n = 1'b1;
    n = 0;
    do begin step_clk(); n++; end while (!ClockOut[0] && n < 20);
    chk("first_rise", n, 4);
    clr();
    repeat (16) step_clk();
    chk("ticks16", rt0, 2);
    chk("period4", last_rise - prev_rise, 8);

    // Scale 0 and 1 both divide by 2.
    scl0 = 4'd0; scl1 = 4'd1;
    repeat (8) step_clk();
    clr();
    repeat (10) step_clk();
    chk("rises_s0", rt0, 5);
    chk("rises_s1", rt1, 5);

    // Largest scale: counter runs to max-1 without wrapping.
    scl0 = 4'd15; scl1 = 4'd15;
    repeat (40) step_clk();
    n = 0;
    do begin step_clk(); n++; end while (!RiseTick[0] && n < 40);
    n = 0;
    do begin step_clk(); n++; end while (!RiseTick[0] && n < 40);
    chk("period15", n, 30);

    // Rescale from 5 to 2 mid-high: current high stays 5, next low is 2.
    scl0 = 4'd5; scl1 = 4'd5;
    n = 0;
    do begin step_clk(); n++; end while (!RiseTick[0] && n < 40);
    n = 0;
    do begin step_clk(); n++; end while (!RiseTick[0] && n < 40);
    hi = 1;
    repeat (2) begin step_clk(); if (ClockOut[0]) hi++; end
    scl0 = 4'd2;
    n = 0;
    while (ClockOut[0] && n < 20) begin step_clk(); n++; if (ClockOut[0]) hi++; end
    chk("hi_len5", hi, 5);
    lo = 1;
    n = 0;
    while (!ClockOut[0] && n < 20) begin step_clk(); n++; if (!ClockOut[0]) lo++; end
    chk("lo_len2", lo, 2);

    // Freeze for 7 cycles mid-high at scale 6, then resume with remaining count.
    scl0 = 4'd6; scl1 = 4'd6;
    n = 0;
    do begin step_clk(); n++; end while (!RiseTick[0] && n < 40);
    n = 0;
    do begin step_clk(); n++; end while (!RiseTick[0] && n < 40);
    repeat (2) step_clk();
    snap = ClockOut;
    Enable = 2'b00;
    clr();
    repeat (7) begin step_clk(); chk("frz_out", 32'(ClockOut), 32'(snap)); end
    chk("frz_tick", rt0 + rt1, 0);
    Enable = 2'b11;
    hi = 0;
    n = 0;
    do begin step_clk(); n++; if (ClockOut[0]) hi++; end while (ClockOut[0] && n < 20);
    chk("resume_hi", hi, 3);

    // Single step at scale 3, with an ignored second request during Busy.
    Reset_n = 1'b0; StepMode = 2'b11; scl0 = 4'd3; scl1 = 4'd3;
    repeat (2) step_clk();
    Reset_n = 1'b1;
    repeat (3) step_clk();
    chk("idle_out", 32'(ClockOut), 0);
    clr();
    StepReq = 2'b01; step_clk();
    StepReq = 2'b00; step_clk();
    StepReq = 2'b01; step_clk();
    StepReq = 2'b00;
    repeat (9) step_clk();
    chk("step_busy", bz0, 6);
    chk("step_rise", rt0, 1);
    chk("step_hi", hi0, 3);
    chk("step_other", rt1, 0);

    // Two channels at 2 and 5; reset lands mid-step on channel 1.
    Reset_n = 1'b0; StepMode = 2'b10; scl0 = 4'd2; scl1 = 4'd5;
    step_clk();
    Reset_n = 1'b1;
    repeat (4) step_clk();
    StepReq = 2'b10; step_clk();
    StepReq = 2'b00;
    repeat (3) step_clk();
    chk("mid_busy", 32'(Busy[1]), 1);
    Reset_n = 1'b0; StepMode = 2'b00;
    step_clk();
    chk("abort_out", 32'(ClockOut), 0);
    chk("abort_busy", 32'(Busy), 0);
    Reset_n = 1'b1;
    n = 0;
    do begin step_clk(); n++; end while (!ClockOut[1] && n < 20);
    chk("restart_rise1", n, 5);
    repeat (20) step_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
